// File: rtl/fsk_ctrl_pkg.sv
// Shared types and defaults for the FSK threshold controller.
// State encoding, sample width and default parameter values.
package fsk_ctrl_pkg;

    localparam int SAMPLE_W = 16;

    localparam int CAL_LOG2_DEF        = 3;
    localparam int TRACK_SHIFT_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF  = 400;
    localparam int DEFAULT_COMPARE_DEF = 200;

    typedef enum logic [1:0] {
        IDLE,
        CALIBRATE,
        TRACK,
        LOST
    } state_t;

endpackage

// File: rtl/fsk_threshold_controller_if.sv
// Sample stream from the frequency counter and decision stream back.
// master = counter side, slave = threshold controller.
interface fsk_threshold_controller_if;
    import fsk_ctrl_pkg::*;

    logic                sample_valid_i;
    logic [SAMPLE_W-1:0] sample_i;
    logic [SAMPLE_W-1:0] compare_point_o;
    logic                bit_o;
    logic                bit_valid_o;

    modport master (
        output sample_valid_i, sample_i,
        input  compare_point_o, bit_o, bit_valid_o
    );

    modport slave (
        input  sample_valid_i, sample_i,
        output compare_point_o, bit_o, bit_valid_o
    );
endinterface

// File: rtl/fsk_threshold_controller_timer.sv
// Saturating no-sample timer with clear/enable.
// expire pulses while the count sits at TIMEOUT_CYCLES-1.
module sample_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [15:0] count;

    assign expire = en && !clr && (count == 16'(TIMEOUT_CYCLES - 1));

    // Count idle cycles; restart on any sample, when stopped, or on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr || expire || !en) begin
            count <= '0;
        end else if (count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/fsk_threshold_controller.sv
// Calibrates and tracks the FSK decision threshold, emits bits,
// and reports lock / loss of signal.
module fsk_threshold_controller
    import fsk_ctrl_pkg::*;
#(
    parameter int CAL_LOG2        = CAL_LOG2_DEF,
    parameter int TRACK_SHIFT     = TRACK_SHIFT_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int DEFAULT_COMPARE = DEFAULT_COMPARE_DEF
) (
    input  logic                        clk_200M,
    input  logic                        reset_200M,
    input  logic                        enable_i,
    input  logic                        recalibrate_i,
    fsk_threshold_controller_if.slave   bus,
    output logic                        locked_o,
    output logic                        signal_lost_o
);
    localparam int ACC_W = SAMPLE_W + CAL_LOG2;

    state_t                state, state_n;
    logic [ACC_W-1:0]      acc, acc_n, sum;
    logic [CAL_LOG2-1:0]   cnt, cnt_n;
    logic [SAMPLE_W-1:0]   cp, cp_n, cp_track;
    logic                  bit_q, bit_n, bv, bv_n;
    logic                  accepted, run, expire;
    logic signed [SAMPLE_W:0]   diff, step;
    logic signed [SAMPLE_W+1:0] nt;

    assign accepted = bus.sample_valid_i && (bus.sample_i != '0);
    assign run      = (state == CALIBRATE) || (state == TRACK);
    assign sum      = acc + ACC_W'(bus.sample_i);

    sample_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk_200M),
        .rst    (reset_200M),
        .clr    (bus.sample_valid_i),
        .en     (run),
        .expire (expire)
    );

    // Tracking step: signed error, arithmetic shift, clamp to 16 bits.
    always_comb begin
        diff     = $signed({1'b0, bus.sample_i}) - $signed({1'b0, cp});
        step     = diff >>> TRACK_SHIFT;
        nt       = $signed({2'b00, cp}) + $signed({step[SAMPLE_W], step});
        cp_track = nt[SAMPLE_W-1:0];
        if (nt[SAMPLE_W+1]) begin
            cp_track = '0;
        end else if (nt[SAMPLE_W]) begin
            cp_track = '1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        cp_n    = cp;
        bit_n   = bit_q;
        bv_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i) begin
                    state_n = CALIBRATE;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            end
            CALIBRATE: begin
                if (accepted) begin
                    if (cnt == '1) begin
                        cp_n    = sum[CAL_LOG2 +: SAMPLE_W];
                        state_n = TRACK;
                    end else begin
                        acc_n = sum;
                        cnt_n = cnt + CAL_LOG2'(1);
                    end
                end else if (expire) begin
                    state_n = LOST;
                end
            end
            TRACK: begin
                if (recalibrate_i) begin
                    state_n = CALIBRATE;
                    acc_n   = '0;
                    cnt_n   = '0;
                end else if (accepted) begin
                    bit_n = (bus.sample_i < cp);
                    bv_n  = 1'b1;
                    cp_n  = cp_track;
                end else if (expire) begin
                    state_n = LOST;
                end
            end
            LOST: begin
                if (accepted) begin
                    state_n = CALIBRATE;
                    acc_n   = ACC_W'(bus.sample_i);
                    cnt_n   = CAL_LOG2'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (!enable_i) begin
            state_n = IDLE;
            cp_n    = cp;
            bit_n   = bit_q;
            bv_n    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_200M) begin
        if (reset_200M) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            cp    <= SAMPLE_W'(DEFAULT_COMPARE);
            bit_q <= 1'b0;
            bv    <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            cp    <= cp_n;
            bit_q <= bit_n;
            bv    <= bv_n;
        end
    end

    assign bus.compare_point_o = cp;
    assign bus.bit_o           = bit_q;
    assign bus.bit_valid_o     = bv;
    assign locked_o            = (state == TRACK);
    assign signal_lost_o       = (state == LOST);
endmodule

// File: tb/tb_fsk_threshold_controller.sv
// Directed-vector bench for fsk_threshold_controller.
// Expected values are hand-derived from the threshold arithmetic.
`timescale 1ns/1ps
module tb_fsk_threshold_controller;
    logic clk_200M = 1'b0;
    logic reset_200M;
    logic enable_i;
    logic recalibrate_i;
    logic locked_o;
    logic signal_lost_o;
    int   vectors = 0;
    int   miscompares = 0;

    fsk_threshold_controller_if bus ();

    fsk_threshold_controller dut (
        .clk_200M      (clk_200M),
        .reset_200M    (reset_200M),
        .enable_i      (enable_i),
        .recalibrate_i (recalibrate_i),
        .bus           (bus),
        .locked_o      (locked_o),
        .signal_lost_o (signal_lost_o)
    );

    always #2.5 clk_200M = ~clk_200M;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_200M);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] s);
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = s;
        tick();
        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
    endtask

    task automatic calib(input logic [15:0] s, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(gap);
            send(s);
        end
    endtask

    initial begin
        reset_200M         = 1'b1;
        enable_i           = 1'b0;
        recalibrate_i      = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
        tick(2);
        reset_200M = 1'b0;
        check("rst_cp", 32'(bus.compare_point_o), 200);
        check("rst_bit", 32'(bus.bit_o), 0);
        check("rst_bv", 32'(bus.bit_valid_o), 0);
        check("rst_lock", 32'(locked_o), 0);
        check("rst_lost", 32'(signal_lost_o), 0);

        enable_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick(199);
            send((i % 2 == 0) ? 16'd198 : 16'd202);
            check("cal_bv", 32'(bus.bit_valid_o), 0);
            if (i == 6) check("cal_lock7", 32'(locked_o), 0);
        end
        check("cal_cp", 32'(bus.compare_point_o), 200);
        check("cal_lock", 32'(locked_o), 1);

        send(16'd199);
        check("t1_bit", 32'(bus.bit_o), 1);
        check("t1_bv", 32'(bus.bit_valid_o), 1);
        check("t1_cp", 32'(bus.compare_point_o), 199);
        tick();
        check("t1_bv_pulse", 32'(bus.bit_valid_o), 0);
        tick(50);
        send(16'd205);
        check("t2_bit", 32'(bus.bit_o), 0);
        check("t2_cp", 32'(bus.compare_point_o), 199);
        send(16'd199);
        check("t3_bit", 32'(bus.bit_o), 0);
        check("t3_bv", 32'(bus.bit_valid_o), 1);
        check("t3_cp", 32'(bus.compare_point_o), 199);

        tick(399);
        check("to_lost399", 32'(signal_lost_o), 0);
        check("to_lock399", 32'(locked_o), 1);
        tick();
        check("to_lost400", 32'(signal_lost_o), 1);
        check("to_lock400", 32'(locked_o), 0);
        tick(5);
        check("lost_cp", 32'(bus.compare_point_o), 199);

        calib(16'd210, 7, 10);
        check("rel_lock7", 32'(locked_o), 0);
        check("rel_cp7", 32'(bus.compare_point_o), 199);
        calib(16'd210, 1, 10);
        check("rel_cp", 32'(bus.compare_point_o), 210);
        check("rel_lock", 32'(locked_o), 1);
        check("rel_lost", 32'(signal_lost_o), 0);

        tick(399);
        send(16'd200);
        check("cancel_lock", 32'(locked_o), 1);
        check("cancel_lost", 32'(signal_lost_o), 0);
        check("cancel_bit", 32'(bus.bit_o), 1);
        check("cancel_cp", 32'(bus.compare_point_o), 209);
        tick(399);
        check("cancel_hold", 32'(locked_o), 1);
        send(16'd220);
        check("t4_bit", 32'(bus.bit_o), 0);
        check("t4_cp", 32'(bus.compare_point_o), 209);

        tick(200);
        send(16'd0);
        check("glitch_bv", 32'(bus.bit_valid_o), 0);
        check("glitch_cp", 32'(bus.compare_point_o), 209);
        tick(399);
        check("glitch_clr", 32'(locked_o), 1);
        tick();
        check("glitch_lost", 32'(signal_lost_o), 1);
        calib(16'd210, 8, 10);
        check("rel2_cp", 32'(bus.compare_point_o), 210);
        check("rel2_lock", 32'(locked_o), 1);

        recalibrate_i = 1'b1;
        send(16'd300);
        recalibrate_i = 1'b0;
        check("recal_lock", 32'(locked_o), 0);
        check("recal_bv", 32'(bus.bit_valid_o), 0);
        check("recal_cp", 32'(bus.compare_point_o), 210);
        calib(16'd100, 7, 10);
        check("recal_lock7", 32'(locked_o), 0);
        calib(16'd100, 1, 10);
        check("recal_cp8", 32'(bus.compare_point_o), 100);
        check("recal_lock8", 32'(locked_o), 1);

        recalibrate_i = 1'b1;
        tick();
        recalibrate_i = 1'b0;
        calib(16'd150, 5, 10);
        enable_i = 1'b0;
        tick();
        check("dis_lock", 32'(locked_o), 0);
        check("dis_lost", 32'(signal_lost_o), 0);
        check("dis_cp", 32'(bus.compare_point_o), 100);
        enable_i = 1'b1;
        tick();
        calib(16'd50, 7, 10);
        check("reen_lock7", 32'(locked_o), 0);
        check("reen_cp7", 32'(bus.compare_point_o), 100);
        calib(16'd50, 1, 10);
        check("reen_cp", 32'(bus.compare_point_o), 50);
        check("reen_lock", 32'(locked_o), 1);

        send(16'd40);
        check("t5_bit", 32'(bus.bit_o), 1);
        check("t5_bv", 32'(bus.bit_valid_o), 1);
        reset_200M = 1'b1;
        tick();
        reset_200M = 1'b0;
        check("mrst_cp", 32'(bus.compare_point_o), 200);
        check("mrst_bit", 32'(bus.bit_o), 0);
        check("mrst_bv", 32'(bus.bit_valid_o), 0);
        check("mrst_lock", 32'(locked_o), 0);
        check("mrst_lost", 32'(signal_lost_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fsk_threshold_controller.md
Name: fsk_threshold_controller

Overview:
Sequencing/calibration controller for the frequency_counter datapath in the 200 MHz domain. It consumes each new period-count sample, calibrates the decision threshold from a sample average, then drives compare_point to the counter and emits demodulated bits. While tracking, it keeps adapting the threshold and flags loss of signal when samples stop arriving.

Parameters:
CAL_LOG2, 3, log2 of calibration sample count (8 samples)
TRACK_SHIFT, 4, threshold adaptation rate: threshold += (sample - threshold) >>> TRACK_SHIFT
TIMEOUT_CYCLES, 400, clk_200M cycles without a sample before declaring loss (about two nominal sample periods)
DEFAULT_COMPARE, 200, compare point used before the first calibration

Ports:
clk_200M  in  1  sole clock
reset_200M  in  1  synchronous, active-high reset
enable_i  in  1  level; 0 forces IDLE
recalibrate_i  in  1  one-cycle pulse; restarts calibration from TRACK
sample_valid_i  in  1  one-cycle pulse; sample_i holds a new count this cycle
sample_i  in  16  period count from the frequency counter (last_sample)
compare_point_o  out  16  threshold to the frequency counter's compare_point_i
bit_o  out  1  demodulated bit; 1 = sample < threshold (input above centre frequency)
bit_valid_o  out  1  one-cycle pulse qualifying bit_o
locked_o  out  1  high only in TRACK
signal_lost_o  out  1  high only in LOST

Behaviour:
- Reset values: compare_point_o = DEFAULT_COMPARE, bit_o = 0, bit_valid_o = 0, locked_o = 0, signal_lost_o = 0, state = IDLE. Accumulator, sample count and timeout counter are all 0.
- States:
  - IDLE: outputs idle. If enable_i = 1, go to CALIBRATE next cycle with the accumulator and count cleared.
  - CALIBRATE: each accepted sample is added to a (16+CAL_LOG2)-bit accumulator.
    - On the 2^CAL_LOG2-th accepted sample: compare_point_o <= (acc + sample) >> CAL_LOG2 (truncating), then go to TRACK.
    - locked_o rises the cycle after that sample.
  - TRACK: each accepted sample registers bit_o <= (sample_i < compare_point_o), with bit_valid_o high the next cycle (latency 1).
    - In the same cycle, compare_point_o updates using the pre-update threshold.
    - The difference is a 17-bit signed value, arithmetically shifted right.
    - The result saturates to 0..65535.
  - LOST: signal_lost_o = 1. The next accepted sample moves to CALIBRATE and counts as its first sample.
- Accepted sample: sample_valid_i = 1 and sample_i != 0. A zero sample is discarded: no bit, no accumulation, but the timeout counter still resets.
- Timeout: a 16-bit saturating counter runs in CALIBRATE and TRACK and clears on any sample_valid_i.
  - It reaching TIMEOUT_CYCLES-1 with no valid sample moves to LOST next cycle.
  - The counter clears on entry to LOST.
- Priority, highest first: reset_200M > enable_i = 0 > recalibrate_i > sample_valid_i > timeout.
  - A valid sample in the timeout cycle cancels the timeout.
  - recalibrate_i together with a valid sample: go to CALIBRATE with the accumulator cleared; the sample is discarded and no bit is produced.
  - recalibrate_i outside TRACK is ignored.
- Returning to IDLE (enable_i = 0) clears locked_o, signal_lost_o and bit_valid_o. compare_point_o retains its value.
- compare_point_o never changes in IDLE or LOST.

Decomposition:
- Shared package fsk_ctrl_pkg holds:
  - state enum (IDLE, CALIBRATE, TRACK, LOST)
  - sample width constant (16)
  - default parameter constants
- One natural sub-module: sample_timeout_timer, a saturating counter with clear and enable and an expiry pulse at TIMEOUT_CYCLES-1.
- Threshold arithmetic stays inline.

Test Plan:
- Calibration: reset, enable, 8 samples alternating 198/202 spaced 200 cycles -> compare_point_o = 200 and locked_o = 1 one cycle after the 8th sample. No bit_valid_o pulse during calibration.
- Tracking decisions:
  - sample 199 -> bit_o = 1, bit_valid_o pulse 1 cycle later, compare_point_o = 199 (-1 >>> 4 = -1).
  - Then sample 205 -> bit_o = 0, compare_point_o stays 199 (6 >>> 4 = 0).
  - Then sample 199 -> bit_o = 0 (not strictly less).
- Loss of signal: in TRACK, stop samples -> signal_lost_o = 1 and locked_o = 0 exactly 400 cycles after the last pulse.
  - A sample of 200 in the expiry cycle instead keeps TRACK.
  - From LOST, 8 samples of 210 -> compare_point_o = 210, TRACK.
- Glitch and recalibration:
  - sample 0 in TRACK -> no bit_valid_o, threshold unchanged, timeout counter cleared.
  - recalibrate_i with a simultaneous sample 300 -> CALIBRATE, sample not accumulated, locked_o = 0.
- Enable and reset mid-operation:
  - enable_i = 0 mid-calibration after 5 samples -> IDLE next cycle, compare_point_o unchanged. Re-enable requires a full 8 new samples.
  - reset_200M in TRACK -> all outputs at reset values next cycle, compare_point_o = 200.
